// File: rtl/arrow_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | arrow_pkg: sprite IDs, chart entry layout and scheduler FSM states.    |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
package arrow_pkg;

  localparam logic [3:0] ID_NONE  = 4'h0;
  localparam logic [3:0] ID_UP    = 4'h4;
  localparam logic [3:0] ID_DOWN  = 4'h5;
  localparam logic [3:0] ID_LEFT  = 4'h6;
  localparam logic [3:0] ID_RIGHT = 4'h7;

  localparam int ENT_END    = 7;
  localparam int ENT_S2_HI  = 6;
  localparam int ENT_S2_LO  = 5;
  localparam int ENT_S3_HI  = 4;
  localparam int ENT_S3_LO  = 3;
  localparam int ENT_GAP_HI = 2;
  localparam int ENT_GAP_LO = 0;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_WAIT  = 3'd2,
    ST_SPAWN = 3'd3,
    ST_GAP   = 3'd4,
    ST_DONE  = 3'd5
  } state_e;

  // Selections 00 and 11 both mean "no arrow" for that slot.
  function automatic logic [3:0] slot2_id(input logic [1:0] sel);
    case (sel)
      2'b01:   return ID_UP;
      2'b10:   return ID_LEFT;
      default: return ID_NONE;
    endcase
  endfunction

  function automatic logic [3:0] slot3_id(input logic [1:0] sel);
    case (sel)
      2'b01:   return ID_DOWN;
      2'b10:   return ID_RIGHT;
      default: return ID_NONE;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/arrow_slot.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | arrow_slot: one on-screen arrow lane - occupancy, scroll and miss.     |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module arrow_slot
  import arrow_pkg::*;
#(
  parameter logic [9:0] SPAWN_Y = 10'd480,
  parameter logic [9:0] MISS_Y  = 10'd8,
  parameter logic [9:0] SPEED   = 10'd4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       tick_i,
  input  logic       hit_i,
  input  logic       load_i,
  input  logic [3:0] load_id_i,
  output logic [3:0] id_o,
  output logic [9:0] posy_o,
  output logic       miss_o,
  output logic       miss_evt_o
);

  logic [3:0] id_q,   id_d;
  logic [9:0] posy_q, posy_d;
  logic       miss_q, miss_d;
  logic       w_occ;

  assign w_occ = (id_q != ID_NONE);

  // Priority: hit, spawn load, miss retire, scroll.
  always_comb begin
    id_d   = id_q;
    posy_d = posy_q;
    miss_d = 1'b0;
    if (hit_i && w_occ) begin
      id_d   = ID_NONE;
      posy_d = '0;
    end else if (load_i) begin
      id_d   = load_id_i;
      posy_d = SPAWN_Y;
    end else if (tick_i && w_occ && (posy_q <= MISS_Y)) begin
      id_d   = ID_NONE;
      posy_d = '0;
      miss_d = 1'b1;
    end else if (tick_i && w_occ) begin
      posy_d = posy_q - SPEED;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      id_q   <= ID_NONE;
      posy_q <= '0;
      miss_q <= 1'b0;
    end else begin
      id_q   <= id_d;
      posy_q <= posy_d;
      miss_q <= miss_d;
    end
  end

  assign id_o       = id_q;
  assign posy_o     = posy_q;
  assign miss_o     = miss_q;
  assign miss_evt_o = miss_d;

endmodule
`default_nettype wire

// File: rtl/arrow_scheduler.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | arrow_scheduler: walks the step chart, spawns and scrolls arrows.      |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module arrow_scheduler
  import arrow_pkg::*;
#(
  parameter int         ADDR_W   = 8,
  parameter logic [9:0] SPAWN_Y  = 10'd480,
  parameter logic [9:0] MISS_Y   = 10'd8,
  parameter logic [9:0] SPEED    = 10'd4,
  parameter logic [7:0] GAP_UNIT = 8'd8
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              vs,
  input  logic              start,
  output logic [ADDR_W-1:0] chart_addr,
  input  logic [7:0]        chart_data,
  input  logic              sprite2hit,
  input  logic              sprite3hit,
  output logic [3:0]        spriteID2,
  output logic [9:0]        posY2,
  output logic [3:0]        spriteID3,
  output logic [9:0]        posY3,
  output logic              miss2,
  output logic              miss3,
  output logic [7:0]        miss_count,
  output logic              busy,
  output logic              done
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q,  addr_d;
  logic [6:0]        entry_q, entry_d;
  logic [10:0]       gap_q,   gap_d;
  logic [7:0]        cnt_q,   cnt_d;
  logic              busy_q,  busy_d;
  logic              done_q,  done_d;
  logic              vs_q;

  logic        w_tick;
  logic [3:0]  w_id2_new, w_id3_new;
  logic        w_want2, w_want3, w_blocked;
  logic        w_load2, w_load3;
  logic        w_evt2, w_evt3;
  logic [10:0] w_gap_load;
  logic [8:0]  w_cnt_sum;

  assign w_tick     = vs & ~vs_q;
  assign w_id2_new  = slot2_id(entry_q[ENT_S2_HI:ENT_S2_LO]);
  assign w_id3_new  = slot3_id(entry_q[ENT_S3_HI:ENT_S3_LO]);
  assign w_want2    = (w_id2_new != ID_NONE);
  assign w_want3    = (w_id3_new != ID_NONE);
  assign w_blocked  = (w_want2 && (spriteID2 != ID_NONE)) ||
                      (w_want3 && (spriteID3 != ID_NONE));
  assign w_gap_load = ({8'd0, entry_q[ENT_GAP_HI:ENT_GAP_LO]} + 11'd1) * {3'd0, GAP_UNIT};
  assign w_cnt_sum  = {1'b0, cnt_q} + {8'd0, w_evt2} + {8'd0, w_evt3};

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    entry_d = entry_q;
    gap_d   = gap_q;
    busy_d  = busy_q;
    done_d  = done_q;
    w_load2 = 1'b0;
    w_load3 = 1'b0;
    cnt_d   = w_cnt_sum[8] ? 8'hFF : w_cnt_sum[7:0];
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          addr_d  = '0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: state_d = ST_WAIT;
      ST_WAIT: begin
        entry_d = chart_data[6:0];
        if (chart_data[ENT_END]) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = ST_DONE;
        end else begin
          state_d = ST_SPAWN;
        end
      end
      ST_SPAWN: begin
        if (!w_blocked) begin
          w_load2 = w_want2;
          w_load3 = w_want3;
          gap_d   = w_gap_load;
          addr_d  = addr_q + ADDR_W'(1);
          state_d = ST_GAP;
        end
      end
      ST_GAP: begin
        if (gap_q == 11'd0) begin
          state_d = ST_FETCH;
        end else if (w_tick) begin
          gap_d = gap_q - 11'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      entry_q <= '0;
      gap_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      vs_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      entry_q <= entry_d;
      gap_q   <= gap_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      vs_q    <= vs;
    end
  end

  arrow_slot #(.SPAWN_Y(SPAWN_Y), .MISS_Y(MISS_Y), .SPEED(SPEED)) u_slot2 (
    .clk_i      (Clk),
    .rst_i      (Reset),
    .tick_i     (w_tick),
    .hit_i      (sprite2hit),
    .load_i     (w_load2),
    .load_id_i  (w_id2_new),
    .id_o       (spriteID2),
    .posy_o     (posY2),
    .miss_o     (miss2),
    .miss_evt_o (w_evt2)
  );

  arrow_slot #(.SPAWN_Y(SPAWN_Y), .MISS_Y(MISS_Y), .SPEED(SPEED)) u_slot3 (
    .clk_i      (Clk),
    .rst_i      (Reset),
    .tick_i     (w_tick),
    .hit_i      (sprite3hit),
    .load_i     (w_load3),
    .load_id_i  (w_id3_new),
    .id_o       (spriteID3),
    .posy_o     (posY3),
    .miss_o     (miss3),
    .miss_evt_o (w_evt3)
  );

  assign chart_addr = addr_q;
  assign miss_count = cnt_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule
`default_nettype wire

// File: doc/arrow_scheduler.md
Name: arrow_scheduler

Overview:
- Producer side of the arrow/judgement path: reads a step chart from a synchronous ROM, spawns arrows at the bottom of the screen and scrolls them up once per frame.
- Drives the spriteID2/posY2 (up/left) and spriteID3/posY3 (down/right) values that the judgement logic consumes.
- Retires an arrow when the judgement logic returns a hit flag; otherwise retires it as a miss when it scrolls past the target zone.

Parameters:
- ADDR_W, 8, chart ROM address width
- SPAWN_Y, 10'd480, posY loaded at spawn
- MISS_Y, 10'd8, an arrow at or below this Y on a frame tick retires as a miss
- SPEED, 10'd4, pixels moved per frame tick
- GAP_UNIT, 8'd8, frames per gap step

Ports:
- Clk  in  1  system clock
- Reset  in  1  synchronous, active-high
- vs  in  1  vertical sync level; rising edge = frame tick
- start  in  1  one-cycle pulse; begins the chart at address 0
- chart_addr  out  ADDR_W  ROM address
- chart_data  in  8  ROM data, valid one cycle after chart_addr
- sprite2hit  in  1  judge reports hit on slot 2
- sprite3hit  in  1  judge reports hit on slot 3
- spriteID2  out  4  slot-2 sprite: 4'h4 up, 4'h6 left, 4'h0 empty
- posY2  out  10  slot-2 Y
- spriteID3  out  4  slot-3 sprite: 4'h5 down, 4'h7 right, 4'h0 empty
- posY3  out  10  slot-3 Y
- miss2, miss3  out  1  one-cycle miss pulses
- miss_count  out  8  saturating miss total
- busy  out  1  chart in progress
- done  out  1  end marker reached; held until next start

Behaviour:
- Reset values: all outputs 0 (spriteIDs 4'h0, posY 0, chart_addr 0, busy 0, done 0, miss_count 0); FSM = IDLE; vs edge register = 0.
- Reset mid-chart clears everything identically; no miss pulses are emitted for live arrows.
- Frame tick: vs_q <= vs; tick = vs & ~vs_q. The tick is a one-cycle pulse in the cycle after vs is sampled high.
- Chart entry fields:
  - [7] end marker
  - [6:5] slot-2 select: 00 none, 01 up, 10 left, 11 none
  - [4:3] slot-3 select: 00 none, 01 down, 10 right, 11 none
  - [2:0] gap; wait (gap+1)*GAP_UNIT frame ticks after spawn
- FSM:
  - IDLE: on start, chart_addr <= 0, busy <= 1, done <= 0, go to FETCH. start in any other state is ignored.
  - FETCH: address stable; go to WAIT.
  - WAIT: latch chart_data. If [7]=1, go to DONE; else go to SPAWN.
  - SPAWN: stall while any selected slot is occupied (spriteID != 0). When all selected slots are free, load spriteID and posY=SPAWN_Y into them, load the gap counter, chart_addr <= chart_addr+1 (wraps at 2^ADDR_W), go to GAP.
  - GAP: decrement the counter on each tick; at 0 go to FETCH.
  - DONE: busy=0, done=1. Slots keep scrolling until they retire. start restarts the chart.
- Latency: start at cycle 0 -> FETCH cycle 1 -> WAIT cycle 2 -> SPAWN cycle 3 -> new spriteID/posY visible at cycle 4 (registered).
- Per-slot update each cycle, highest priority first:
  1. hit=1 and occupied: clear to empty, no miss.
  2. Spawn load: posY=SPAWN_Y, no decrement this cycle even if tick.
  3. tick and occupied and posY <= MISS_Y: clear, pulse missN for 1 cycle.
  4. tick and occupied: posY <= posY - SPEED.
- Boundary cases:
  - Hit on an empty slot is ignored.
  - Hit and miss condition in the same cycle: hit wins.
  - Both slots miss in the same cycle: miss_count += 2, saturating at 8'hFF.
  - A selection of 00 or 11 leaves that slot untouched and never stalls on it.
  - An entry with both selections none acts as a pure rest and spawns nothing.
- Empty slots hold posY at 0.

Decomposition:
- arrow_pkg holds:
  - sprite ID constants: ID_NONE=0, ID_UP=4, ID_DOWN=5, ID_LEFT=6, ID_RIGHT=7
  - the chart entry field offsets
  - the FSM state enum (IDLE, FETCH, WAIT, SPAWN, GAP, DONE)
- Sub-module arrow_slot (one instance per slot) owns the occupancy/posY/miss logic with inputs tick, hit, load, load_id.
- The top level holds the FSM, gap counter, edge detect and miss_count.

Test Plan:
- Reset: assert Reset mid-GAP with both slots live -> next cycle all outputs 0, no miss pulse, FSM IDLE.
- Spawn: chart[0]=8'b0_01_00_000 (up, gap 0); start at cycle 0 -> spriteID2=4'h4, posY2=480 at cycle 4. After 10 ticks posY2=440. chart_addr=1.
- Miss: let an up arrow scroll unhit -> retires on the tick where posY2=8 (tick 119 after spawn). miss2 pulses once, miss_count=1, spriteID2=0.
- Hit priority: assert sprite2hit in the same cycle as the miss tick -> slot cleared, miss2 stays 0, miss_count unchanged.
- Stall: chart[0]=8'b0_01_10_000, chart[1]=8'b0_10_00_000 -> the second spawn waits in SPAWN until slot 2 clears; a hit pulse frees it and left (4'h6) loads on the next cycle.
- End and restart: chart[1]=8'h80 -> done=1, busy=0. Both-miss tick gives miss_count +2 (255 saturates). A new start re-fetches address 0.
